// File: rtl/mdu_iter.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide with valid/ready handshakes.
// Optional MDU_FAST_MUL_EN computes all multiplies in one cycle with a combinational multiplier.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [XLEN-1:0]  req_rs1_i,
    input  logic [XLEN-1:0]  req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [XLEN-1:0]  resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             busy_o
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               a_neg_reg, b_neg_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [XLEN-1:0]    hi_reg, lo_reg, b_reg;
    logic [XLEN-1:0]    resp_data_reg;

    logic               accept;
    logic               a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic [XLEN-1:0]    a_mag_in, b_mag_in;
    logic               div_zero, div_ovf, special_in;
    logic [XLEN-1:0]    special_data;
    logic [XLEN:0]      mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [XLEN-1:0]    step_hi, step_lo;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix, rem_fix, final_data;

    assign req_ready_o  = (state_reg == IDLE) & ~flush_i;
    assign accept       = req_valid_i & req_ready_o;
    assign resp_valid_o = (state_reg == DONE);
    assign resp_data_o  = resp_data_reg;
    assign resp_tag_o   = tag_reg;
    assign busy_o       = (state_reg != IDLE);

    // Operand decode and sign-magnitude conversion at accept
    always_comb begin
        a_signed_in = (req_op_i == 3'b001) | (req_op_i == 3'b010) |
                      (req_op_i == 3'b100) | (req_op_i == 3'b110);
        b_signed_in = (req_op_i == 3'b001) | (req_op_i == 3'b100) | (req_op_i == 3'b110);
        a_neg_in    = a_signed_in & req_rs1_i[XLEN-1];
        b_neg_in    = b_signed_in & req_rs2_i[XLEN-1];
        a_mag_in    = a_neg_in ? -req_rs1_i : req_rs1_i;
        b_mag_in    = b_neg_in ? -req_rs2_i : req_rs2_i;
        div_zero    = req_op_i[2] & (req_rs2_i == '0);
        div_ovf     = req_op_i[2] & ~req_op_i[0] & ~div_zero &
                      (req_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&req_rs2_i);
        special_data = '0;
        if (div_zero)
            special_data = req_op_i[1] ? req_rs1_i : '1;
        else if (div_ovf)
            special_data = req_op_i[1] ? '0 : req_rs1_i;
        special_in = div_zero | div_ovf;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_fix;
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, a_mag_in} * {{XLEN{1'b0}}, b_mag_in};
        fast_fix  = (a_neg_in ^ b_neg_in) ? -fast_prod : fast_prod;
    end
    wire fast_mul = ~req_op_i[2];
    wire [XLEN-1:0] fast_data = (req_op_i[1:0] == 2'b00) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
`endif

    // One iteration step plus the sign fix applied on the last step
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        div_ge    = ~div_diff[XLEN];
        if (op_reg[2]) begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {lo_reg[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
        prod_fix = (a_neg_reg ^ b_neg_reg) ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo_fix  = (a_neg_reg ^ b_neg_reg) ? -step_lo : step_lo;
        rem_fix  = a_neg_reg ? -step_hi : step_hi;
        if (op_reg[2])
            final_data = op_reg[1] ? rem_fix : quo_fix;
        else
            final_data = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
`ifdef MDU_FAST_MUL_EN
                    state_next = (special_in | fast_mul) ? DONE : CALC;
`else
                    state_next = special_in ? DONE : CALC;
`endif
                end
            end
            CALC:    if (cnt_reg == '0) state_next = DONE;
            DONE:    if (resp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i)
            state_next = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            tag_reg       <= '0;
            a_neg_reg     <= 1'b0;
            b_neg_reg     <= 1'b0;
            cnt_reg       <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            b_reg         <= '0;
            resp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && accept) begin
                op_reg    <= req_op_i;
                tag_reg   <= req_tag_i;
                a_neg_reg <= a_neg_in;
                b_neg_reg <= b_neg_in;
                cnt_reg   <= CNT_W'(XLEN-1);
                hi_reg    <= '0;
                lo_reg    <= a_mag_in;
                b_reg     <= b_mag_in;
                if (special_in)
                    resp_data_reg <= special_data;
`ifdef MDU_FAST_MUL_EN
                else if (fast_mul)
                    resp_data_reg <= fast_data;
`endif
            end else if (state_reg == CALC) begin
                cnt_reg <= cnt_reg - 1'b1;
                hi_reg  <= step_hi;
                lo_reg  <= step_lo;
                if (cnt_reg == '0)
                    resp_data_reg <= final_data;
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (XLEN=32): multiply, divide, special cases,
// backpressure, flush and asynchronous reset.
module tb_mdu_iter;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       req_op_i;
    logic [XLEN-1:0]  req_rs1_i, req_rs2_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [XLEN-1:0]  resp_data_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             busy_o;

    int n_cmp = 0;
    int n_err = 0;

    mdu_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_tag_i(req_tag_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        req_op_i    = op;
        req_rs1_i   = a;
        req_rs2_i   = b;
        req_tag_i   = tag;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        req_rs1_i   = 32'hDEAD_BEEF;
        req_rs2_i   = 32'h1234_5678;
        req_tag_i   = 5'h1F;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!resp_valid_o && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input int lat);
        int cyc;
        chk({name, "_ready"}, 32'(req_ready_o), 32'd1);
        issue(op, a, b, tag);
        wait_valid(cyc);
        chk({name, "_lat"}, 32'(cyc), 32'(lat));
        chk({name, "_data"}, resp_data_o, exp);
        chk({name, "_tag"}, 32'(resp_tag_o), 32'(tag));
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        chk({name, "_vdrop"}, 32'(resp_valid_o), 32'd0);
        $display("txn %-8s a=0x%08h b=0x%08h -> 0x%08h tag=%0d lat=%0d", name, a, b, exp, tag, cyc);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [31:0] held_data;
        rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b0;
        req_op_i = 3'b000; req_rs1_i = '0; req_rs2_i = '0; req_tag_i = '0;
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_data", resp_data_o, 32'd0);
        chk("rst_tag", 32'(resp_tag_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("rst_ready", 32'(req_ready_o), 32'd1);

        run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, MUL_LAT);
        run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, MUL_LAT);
        run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, MUL_LAT);
        run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, MUL_LAT);
        run_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
        run_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
        run_op("DIVU",   3'b101, 32'hFFFFFFF9, 32'd2,        5'd9,  32'h7FFFFFFC, 33);
        run_op("DIV0",   3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1);
        run_op("REMU0",  3'b111, 32'd5,        32'd0,        5'd11, 32'd5,        1);
        run_op("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
        run_op("REMOVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1);

        // Backpressure: response held while a new request is offered
        issue(3'b101, 32'd1000, 32'd10, 5'd21);
        wait_valid(cyc);
        chk("bp_lat", 32'(cyc), 32'd33);
        held_data = resp_data_o;
        chk("bp_data", held_data, 32'd100);
        req_valid_i = 1'b1; req_op_i = 3'b100; req_rs1_i = 32'd5; req_rs2_i = 32'd0; req_tag_i = 5'd2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 32'(req_ready_o), 32'd0);
            tick();
            chk("bp_valid", 32'(resp_valid_o), 32'd1);
            chk("bp_hold_data", resp_data_o, 32'd100);
            chk("bp_hold_tag", 32'(resp_tag_o), 32'd21);
        end
        resp_ready_i = 1'b1;
        tick();
        req_valid_i = 1'b0; resp_ready_i = 1'b0;
        chk("bp_vdrop", 32'(resp_valid_o), 32'd0);
        chk("bp_ready_after", 32'(req_ready_o), 32'd1);
        $display("txn BP       DIVU 1000/10 held 5 cycles -> 0x%08h", held_data);

        // Flush in cycle 10 with a competing request
        issue(3'b101, 32'h0000FFFF, 32'd3, 5'd14);
        repeat (9) tick();
        flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = 3'b100; req_rs1_i = 32'd5; req_rs2_i = 32'd0;
        #1;
        chk("fl_ready", 32'(req_ready_o), 32'd0);
        tick();
        flush_i = 1'b0; req_valid_i = 1'b0;
        chk("fl_busy", 32'(busy_o), 32'd0);
        chk("fl_valid", 32'(resp_valid_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid_o) seen++;
            tick();
        end
        chk("fl_never_valid", 32'(seen), 32'd0);
        $display("txn FLUSH    DIVU aborted in cycle 10, valid cycles seen=%0d", seen);
        run_op("DIVU_PF", 3'b101, 32'd100, 32'd7, 5'd15, 32'd14, 33);

        // Asynchronous reset mid-CALC
        issue(3'b101, 32'd12345, 32'd67, 5'd16);
        repeat (5) tick();
        #3 rst_ni = 1'b0;
        #1;
        chk("ar_valid", 32'(resp_valid_o), 32'd0);
        chk("ar_busy", 32'(busy_o), 32'd0);
        chk("ar_data", resp_data_o, 32'd0);
        #2 rst_ni = 1'b1;
        tick();
        $display("txn ARST     reset asserted mid-CALC");
        run_op("MULHU_AR", 3'b011, 32'h00010000, 32'h00030000, 5'd17, 32'h00000003, MUL_LAT);
        run_op("REM_AR",   3'b110, 32'd7,        32'hFFFFFFFE, 5'd18, 32'd1,        33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle RV M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the single-cycle ALU in the execute stage and takes the same operand width.
- Radix-2 iterative shift-add multiply and restoring divide, with valid/ready request and response handshakes.
- Passes a tag through unchanged and supports pipeline flush.

Parameters:
- XLEN, 32, operand/result width; even, >= 8.
- TAG_W, 5, width of the pass-through tag (rd index / ROB id).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- flush_i  in  1  abort in-flight op, drop pending response
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept request
- req_op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_rs1_i  in  XLEN  operand a / dividend
- req_rs2_i  in  XLEN  operand b / divisor
- req_tag_i  in  TAG_W  tag
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer takes result
- resp_data_o  out  XLEN  result
- resp_tag_o  out  TAG_W  tag of result
- busy_o  out  1  state != IDLE

Behaviour:
- One clock; reset is asynchronous and active-low (rst_ni).
- Reset values:
  - state IDLE, resp_valid_o 0, resp_data_o 0, resp_tag_o 0, busy_o 0.
  - req_ready_o 1 once rst_ni is high.
- FSM states: IDLE, CALC, DONE.
- req_ready_o = (state==IDLE) & ~flush_i. Accept = req_valid_i & req_ready_o.
- IDLE -> CALC on accept. Operands, op and tag are registered; the cycle counter loads XLEN-1.
- IDLE -> DONE directly on a special case:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow: DIV with rs1 = 100..0 and rs2 = all-ones gives rs1; REM gives 0.
- CALC:
  - One bit per cycle; counter decrements.
  - Counter==0 -> DONE, applying the final sign fix into resp_data_o.
  - Exactly XLEN CALC cycles.
- Latency: accept in cycle 0 -> resp_valid_o high in cycle XLEN+1 (iterative), or in cycle 1 (special case).
- DONE:
  - resp_valid_o=1. resp_data_o and resp_tag_o are held stable while resp_ready_i=0.
  - resp_valid_o & resp_ready_i -> IDLE; resp_valid_o drops next cycle.
  - No new request is accepted in DONE, even on the response-handshake cycle.
- Signed handling:
  - Signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both) are converted to magnitude at accept.
  - Signs are recorded.
- Result sign rules:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Multiply:
  - 2*XLEN-bit accumulator. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring algorithm with XLEN+1-bit partial remainder. Quotient is truncated toward zero.
- flush_i:
  - Forces IDLE from any state at the next edge. No response is produced; resp_valid_o is 0 the cycle after.
  - Takes priority over the response handshake and over accept.
- Reset mid-operation: immediately returns to the reset values; the result is lost.
- Input operands are don't-care outside the accept cycle.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined:
  - MUL* ops compute with a single XLEN x XLEN combinational multiplier at accept and go IDLE -> DONE.
  - resp_valid_o is high in cycle 1. Divide is unchanged (iterative).
- Undefined:
  - All multiplies iterate XLEN cycles; there is no hardware multiplier array.

Test Plan (XLEN=32):
- Multiply:
  - MUL 7 x 0xFFFFFFFD, tag 3 -> resp 0xFFFFFFEB, tag 3, resp_valid_o first high in cycle 33 (cycle 1 with MDU_FAST_MUL_EN).
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Signed divide/remainder:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - Each has latency 33.
- Special cases, each valid in cycle 1:
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Backpressure:
  - Hold resp_ready_i=0 for 5 cycles after resp_valid_o rises -> data/tag stable, req_ready_o=0.
  - Then resp_ready_i=1 -> resp_valid_o=0 and req_ready_o=1 next cycle.
- Flush:
  - Assert flush_i in cycle 10 of a DIVU, with req_valid_i=1 in the same cycle -> no accept, resp_valid_o never rises, IDLE next cycle.
  - A following DIVU 100 / 7 -> 14.
- Async reset:
  - Pull rst_ni low mid-CALC, between clock edges -> resp_valid_o=0, busy_o=0 immediately.
  - Next request after release completes normally.
